// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: host FSM state encoding and ALU opcode constants shared with the UART ALU
package uart_alu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      SEND_OP,
      WAIT_RES,
      DONE
   } state_t;

   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_host.sv
// uart_alu_host: sends A, B, opcode over a UART TX FIFO and collects one result byte from the RX FIFO
module uart_alu_host
   import uart_alu_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int OPCODE_BITS    = 6,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [DATA_BITS-1:0]   i_op_a,
   input  logic [DATA_BITS-1:0]   i_op_b,
   input  logic [OPCODE_BITS-1:0] i_op_code,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_timeout,
   output logic [DATA_BITS-1:0]   o_result,
   output logic                   o_wr_uart,
   output logic [DATA_BITS-1:0]   o_w_data,
   input  logic                   i_tx_full,
   output logic                   o_rd_uart,
   input  logic [DATA_BITS-1:0]   i_r_data,
   input  logic                   i_rx_empty
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   state_t               state;
   logic [DATA_BITS-1:0] a_q, b_q, op_q;
   logic [CW-1:0]        cnt;
   logic                 sending, tmo_hit;

   // FIFO strobes follow the live full/empty flags so a blocked byte is never lost or repeated
   assign sending   = (state == SEND_A) || (state == SEND_B) || (state == SEND_OP);
   assign tmo_hit   = (state == WAIT_RES) && i_rx_empty && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign o_wr_uart = !i_reset && sending && !i_tx_full;
   assign o_rd_uart = !i_reset && !i_rx_empty && ((state == WAIT_RES) || ((state == IDLE) && !i_start));
   assign o_w_data  = (state == SEND_A) ? a_q : (state == SEND_B) ? b_q : (state == SEND_OP) ? op_q : '0;
   assign o_busy    = state != IDLE;
   assign o_done    = state == DONE;

   // Transaction sequencer, operand latches, result register and WAIT_RES timeout counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         cnt       <= '0;
         o_result  <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= tmo_hit;
         case (state)
            IDLE: if (i_start) begin
               a_q   <= i_op_a;
               b_q   <= i_op_b;
               op_q  <= DATA_BITS'(i_op_code);
               state <= SEND_A;
            end
            SEND_A: if (!i_tx_full) state <= SEND_B;
            SEND_B: if (!i_tx_full) state <= SEND_OP;
            SEND_OP: if (!i_tx_full) begin
               cnt   <= '0;
               state <= WAIT_RES;
            end
            WAIT_RES: if (!i_rx_empty) begin
               o_result <= i_r_data;
               state    <= DONE;
            end else if (tmo_hit) begin
               state <= IDLE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The host never pushes and pops in the same cycle
   assert property (@(posedge i_clk) !(o_wr_uart && o_rd_uart));

endmodule

// File: tb/tb_uart_alu_host.sv
// tb_uart_alu_host: directed scoreboard bench for uart_alu_host with a modelled RX FIFO
module tb_uart_alu_host;
   import uart_alu_pkg::*;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic       clk = 0, rst = 1, start = 0, tx_full = 0, rx_empty = 1;
   logic [7:0] op_a = 0, op_b = 0, r_data = 0;
   logic [5:0] op_code = 0;
   logic       wr, rd, busy, done, tmo;
   logic [7:0] w_data, result;

   exp_t       wr_q[$], done_q[$], tmo_q[$];
   logic [7:0] rx_q[$];
   int         cyc = 0, nvec = 0, nerr = 0, wr_cnt = 0, rd_cnt = 0, last_rd = -1;
   bit         pop_pend = 0;

   uart_alu_host #(.DATA_BITS(8), .OPCODE_BITS(6), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_op_a(op_a), .i_op_b(op_b),
      .i_op_code(op_code), .o_busy(busy), .o_done(done), .o_timeout(tmo),
      .o_result(result), .o_wr_uart(wr), .o_w_data(w_data), .i_tx_full(tx_full),
      .o_rd_uart(rd), .i_r_data(r_data), .i_rx_empty(rx_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      nvec++;
      nerr++;
      $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   task automatic rx_refresh();
      rx_empty = rx_q.size() == 0;
      r_data   = rx_empty ? 8'h00 : rx_q[0];
   endtask

   task automatic rx_push(input logic [7:0] d);
      rx_q.push_back(d);
      rx_refresh();
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                            input int ob, input int oo, output int s);
      op_a = a; op_b = b; op_code = op; start = 1; s = cyc;
      wr_q.push_back('{a, s + 1});
      wr_q.push_back('{b, s + ob});
      wr_q.push_back('{{2'b00, op}, s + oo});
      cycles(1);
      start = 0; op_a = 8'hee; op_b = 8'hdd; op_code = 6'h3f;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         cycles(1);
         n++;
      end
      if (n >= 100) fail("idle_wait_expired", n);
      cycles(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_timeout"}, tmo, 0);
      check({tag, "_wr"}, wr, 0);
      check({tag, "_rd"}, rd, 0);
      check({tag, "_w_data"}, w_data, 0);
      check({tag, "_result"}, result, 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RX FIFO model: a pop seen during a cycle takes effect just after the closing edge
   always @(posedge clk) begin
      #1;
      if (pop_pend) begin
         if (rx_q.size() > 0) void'(rx_q.pop_front());
         pop_pend = 0;
         rx_refresh();
      end
   end

   // Monitor: pops expectations whenever the DUT presents a write, done or timeout
   always @(negedge clk) begin
      exp_t e;
      if (wr) begin
         wr_cnt++;
         if (wr_q.size() == 0) fail("unexpected_write", w_data);
         else begin
            e = wr_q.pop_front();
            check("w_data", w_data, e.d);
            if (e.c >= 0) check("w_cycle", cyc, e.c);
         end
      end
      if (rd) begin
         rd_cnt++;
         last_rd = cyc;
         pop_pend = 1;
         if (wr) fail("wr_rd_overlap", 1);
      end
      if (done) begin
         if (done_q.size() == 0) fail("unexpected_done", result);
         else begin
            e = done_q.pop_front();
            check("done_result", result, e.d);
            if (e.c >= 0) check("done_cycle", cyc, e.c);
         end
      end
      if (tmo) begin
         if (tmo_q.size() == 0) fail("unexpected_timeout", result);
         else begin
            e = tmo_q.pop_front();
            check("timeout_result", result, e.d);
            check("timeout_cycle", cyc, e.c);
            check("timeout_busy", busy, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s, w0, r0;
      cycles(3);
      check_reset_outputs("reset");
      rst = 0;
      cycles(2);

      // basic transaction, result arrives in WAIT_RES
      w0 = wr_cnt; r0 = rd_cnt;
      start_txn(8'h05, 8'h03, OP_ADD, 2, 3, s);
      cycles(3);
      rx_push(8'h08);
      done_q.push_back('{8'h08, s + 5});
      wait_idle();
      check("t1_writes", wr_cnt - w0, 3);
      check("t1_reads", rd_cnt - r0, 1);
      check("t1_result_hold", result, 8'h08);

      // TX back-pressure during SEND_B for 4 cycles
      w0 = wr_cnt;
      start_txn(8'h0a, 8'h03, OP_SUB, 6, 7, s);
      cycles(1);
      tx_full = 1;
      cycles(4);
      tx_full = 0;
      cycles(2);
      rx_push(8'h07);
      done_q.push_back('{8'h07, s + 9});
      wait_idle();
      check("t2_writes", wr_cnt - w0, 3);

      // no result byte: timeout 16 cycles after WAIT_RES entry
      r0 = rd_cnt;
      start_txn(8'h01, 8'h02, OP_AND, 2, 3, s);
      tmo_q.push_back('{8'h07, s + 20});
      wait_idle();
      check("t3_reads", rd_cnt - r0, 0);
      check("t3_result_hold", result, 8'h07);

      // two stale bytes drained in IDLE, then a start pulse during SEND_A is ignored
      r0 = rd_cnt;
      rx_push(8'h55);
      rx_push(8'h66);
      cycles(4);
      check("t4_stale_pops", rd_cnt - r0, 2);
      check("t4_result_hold", result, 8'h07);
      check("t4_rx_drained", rx_empty, 1);
      w0 = wr_cnt;
      start_txn(8'h21, 8'h13, OP_OR, 2, 3, s);
      start = 1; op_a = 8'hff; op_b = 8'hff;
      cycles(1);
      start = 0;
      cycles(2);
      rx_push(8'h99);
      done_q.push_back('{8'h99, s + 5});
      wait_idle();
      cycles(6);
      check("t4_writes", wr_cnt - w0, 3);

      // reset after the first byte aborts the command
      w0 = wr_cnt;
      start_txn(8'h05, 8'h03, OP_ADD, 2, 3, s);
      cycles(1);
      void'(wr_q.pop_back());
      void'(wr_q.pop_back());
      rst = 1;
      cycles(1);
      check_reset_outputs("midreset");
      rst = 0;
      cycles(6);
      check("t5_writes", wr_cnt - w0, 1);
      w0 = wr_cnt;
      start_txn(8'h0c, 8'h04, OP_XOR, 2, 3, s);
      cycles(3);
      rx_push(8'h30);
      done_q.push_back('{8'h30, s + 5});
      wait_idle();
      check("t5_new_writes", wr_cnt - w0, 3);

      // start coinciding with a stale byte: no pop in the start cycle
      r0 = rd_cnt;
      rx_push(8'h44);
      start_txn(8'h01, 8'h01, OP_ADD, 2, 3, s);
      done_q.push_back('{8'h44, s + 5});
      wait_idle();
      check("t6_reads", rd_cnt - r0, 1);
      check("t6_read_cycle", last_rd, s + 4);

      check("wr_q_left", wr_q.size(), 0);
      check("done_q_left", done_q.size(), 0);
      check("tmo_q_left", tmo_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_alu_host.md
UART_ALU_HOST -- requirements
Module: uart_alu_host

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: operand, result and UART byte width.
REQ-002 SHALL have parameter OPCODE_BITS, default 6: opcode width, with OPCODE_BITS <= DATA_BITS.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2**20: result wait limit in clocks.
REQ-004 SHALL have i_clk  in  1  single clock for all logic.
REQ-005 SHALL have i_reset  in  1  reset, synchronous and active-high.
REQ-006 SHALL have i_start  in  1  transaction request, sampled only in IDLE.
REQ-007 SHALL have i_op_a, i_op_b  in  DATA_BITS each  operands.
REQ-008 SHALL have i_op_code  in  OPCODE_BITS  ALU opcode.
REQ-009 SHALL have o_busy  out  1  high in every state except IDLE.
REQ-010 SHALL have o_done  out  1  one-cycle pulse when o_result is valid.
REQ-011 SHALL have o_timeout  out  1  one-cycle pulse on result timeout.
REQ-012 SHALL have o_result  out  DATA_BITS  last received result byte.
REQ-013 SHALL have o_wr_uart  out  1  TX FIFO write strobe.
REQ-014 SHALL have o_w_data  out  DATA_BITS  TX FIFO write data.
REQ-015 SHALL have i_tx_full  in  1  TX FIFO full.
REQ-016 SHALL have o_rd_uart  out  1  RX FIFO read strobe (pop).
REQ-017 SHALL have i_r_data  in  DATA_BITS  RX FIFO head data, valid while i_rx_empty=0.
REQ-018 SHALL have i_rx_empty  in  1  RX FIFO empty.

Function
REQ-019 SHALL implement FSM states IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES and DONE.
REQ-020 SHALL, in IDLE with i_start=1, capture i_op_a, i_op_b and i_op_code and enter SEND_A next cycle; later input changes SHALL NOT affect the transaction.
REQ-021 SHALL ignore i_start in every state other than IDLE, with no queuing.
REQ-022 SHALL, in SEND_x with i_tx_full=0, assert o_wr_uart for exactly one cycle with o_w_data equal to the latched byte and advance: SEND_A -> SEND_B -> SEND_OP -> WAIT_RES.
REQ-023 SHALL, in SEND_x with i_tx_full=1, hold the state with o_wr_uart=0 and no byte dropped or duplicated.
REQ-024 SHALL send the byte order A, B, opcode; the opcode byte is zero-extended to DATA_BITS.
REQ-025 SHALL, in WAIT_RES with i_rx_empty=0, assert o_rd_uart for one cycle, load o_result from i_r_data in that same cycle, and enter DONE.
REQ-026 SHALL, in DONE, pulse o_done for one cycle and return to IDLE; o_result holds until the next successful read.
REQ-027 SHALL count clocks in WAIT_RES from 0; at count TIMEOUT_CYCLES-1 with i_rx_empty=1, pulse o_timeout, leave o_result unchanged and return to IDLE.
REQ-028 SHALL give the result read priority when the RX byte arrives in the timeout cycle: read, no o_timeout.
REQ-029 SHALL, in IDLE with i_rx_empty=0, pop stale RX bytes by asserting o_rd_uart every cycle while the FIFO is non-empty, discarding the data.
REQ-030 SHALL, when i_start and the stale-drain condition coincide in IDLE, start the transaction and suppress o_rd_uart in that cycle.
REQ-031 SHALL keep minimum latency from i_start to the last write at 3 cycles (writes in cycles 1, 2 and 3 relative to start).
REQ-032 SHALL keep o_wr_uart and o_rd_uart never high in the same cycle.

Reset
REQ-033 SHALL, while i_reset=1 at a clock edge, go to IDLE and force o_busy=0, o_done=0, o_timeout=0, o_wr_uart=0, o_rd_uart=0, o_w_data=0, o_result=0, timeout counter=0 and latched operands=0.
REQ-034 SHALL abort any transaction on reset mid-operation, including a partially sent command, with no further FIFO strobes until a new i_start.

Structure
REQ-035 SHALL place the state encoding and the opcode constants shared with the ALU in package uart_alu_pkg.
REQ-036 SHALL have no sub-module; the FSM and timeout counter are implemented in this module.

Verification
REQ-037 SHALL cover: A=0x05, B=0x03, op=0x20, tx never full -> writes 0x05, 0x03, 0x20 in cycles 1-3; RX byte 0x08 presented -> single o_rd_uart, o_result=0x08, o_done pulse.
REQ-038 SHALL cover: i_tx_full=1 for 4 cycles during SEND_B -> no write in those cycles, 0x03 written once after release, exactly 3 writes total.
REQ-039 SHALL cover: TIMEOUT_CYCLES=16, no RX byte -> o_timeout pulses 16 cycles after WAIT_RES entry, o_result unchanged, o_busy=0.
REQ-040 SHALL cover: 2 stale RX bytes in IDLE -> 2 o_rd_uart pops, o_result unchanged; i_start pulsed during SEND_A -> ignored.
REQ-041 SHALL cover: i_reset asserted after the write of 0x05 -> all outputs at reset values next cycle, no further writes; a new transaction then completes normally.
